// File: rtl/game_timer_pkg.sv
// game_timer_pkg: state encoding and counter constants shared by the game timer blocks.
package game_timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_EXP   = 2'd3
  } state_e;
  localparam logic [7:0] TIMER_START_VALUE = 8'd20;
  localparam logic [7:0] COUNT_MAX = 8'd255;
endpackage

// File: rtl/game_tick_prescaler.sv
// game_tick_prescaler: free-running 0..TICK_CYCLES-1 counter; tick marks the terminal count.
module game_tick_prescaler #(
  parameter int TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(TICK_CYCLES);
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = enable && (cnt_q == LAST);
  assign cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_timer_controller.sv
// game_timer_controller: game-time FSM issuing per-second decrements and queued bonus
// increments to the 8-bit time counter, with game-over detection.
module game_timer_controller
  import game_timer_pkg::*;
#(
  parameter int TICK_CYCLES   = 100000000,
  parameter int BONUS_SECONDS = 2,
  parameter int PEND_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus_hit,
  input  logic [7:0] count,
  output logic       timer_reset,
  output logic       increment,
  output logic       decrement,
  output logic       game_over,
  output logic [1:0] state
);
  localparam int PEND_MAX = (1 << PEND_W) - 1;
  state_e state_q, state_d;
  logic tr_q, tr_d, inc_q, inc_d, dec_q, dec_d, over_q, settle_q, tick, run;
  logic [PEND_W-1:0] pend_q, pend_d;
  int pend_sum;
  assign run = (state_q == ST_RUN) && !start && !pause;
  game_tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable (run),
    .tick   (tick)
  );
  // settle_q covers the cycle a pulse is on the wire, so count is only trusted once it has landed
  always_comb begin
    state_d  = state_q;
    tr_d     = 1'b0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    pend_d   = pend_q;
    pend_sum = 0;
    if (start) begin
      state_d = ST_RUN;
      tr_d    = 1'b1;
      pend_d  = '0;
    end else if (state_q == ST_PAUSE && pause) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && pause) begin
      state_d = ST_PAUSE;
    end else if (run && !settle_q && count == 8'd0) begin
      state_d = ST_EXP;
      pend_d  = '0;
    end else if (run) begin
      dec_d    = tick;
      inc_d    = !tick && pend_q != '0 && !settle_q && count != COUNT_MAX;
      pend_sum = int'(pend_q) + (bonus_hit ? BONUS_SECONDS : 0) - int'(inc_d);
      pend_d   = pend_sum > PEND_MAX ? PEND_W'(PEND_MAX) : PEND_W'(pend_sum);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tr_q     <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      over_q   <= 1'b0;
      settle_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      tr_q     <= tr_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      over_q   <= state_d == ST_EXP;
      settle_q <= tr_d | inc_d | dec_d;
      pend_q   <= pend_d;
    end
  end
  assign timer_reset = tr_q;
  assign increment   = inc_q;
  assign decrement   = dec_q;
  assign game_over   = over_q;
  assign state       = state_q;
endmodule

// File: tb/tb_game_timer_controller.sv
// tb_game_timer_controller: vector table plus corner-case sequences against a behavioural time counter.
module tb_game_timer_controller;
  import game_timer_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, bonus_hit = 1'b0;
  logic [7:0] count;
  logic timer_reset, increment, decrement, game_over;
  logic [1:0] state;
  logic [7:0] cnt_m = 8'd0, load_val = 8'd0;
  logic load = 1'b0;
  int n_cmp = 0, n_err = 0, n_inc = 0, n_dec = 0;
  typedef struct { logic s; logic p; logic b; logic [13:0] exp; } vec_t;
  vec_t tbl[$];
  logic [13:0] sb[$];

  always #5 clk = ~clk;
  assign count = cnt_m;

  game_timer_controller #(.TICK_CYCLES(4), .BONUS_SECONDS(2), .PEND_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .bonus_hit(bonus_hit),
    .count(count), .timer_reset(timer_reset), .increment(increment), .decrement(decrement),
    .game_over(game_over), .state(state)
  );

  always @(posedge clk)
    cnt_m <= load ? load_val : timer_reset ? TIMER_START_VALUE :
             increment ? cnt_m + 8'd1 : decrement ? cnt_m - 8'd1 : cnt_m;

  always @(posedge clk)
    if (increment && decrement) begin
      n_err++;
      $display("FAIL inc_dec_overlap: increment=1 decrement=1 at %0t, required never both", $time);
    end

  function automatic logic [13:0] mk(input int tr, input int inc, input int dec, input int go,
                                     input int st, input int c);
    return {tr[0], inc[0], dec[0], go[0], st[1:0], c[7:0]};
  endfunction

  function automatic logic [13:0] snap();
    return {timer_reset, increment, decrement, game_over, state, count};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (increment) n_inc++;
    if (decrement) n_dec++;
  endtask

  task automatic cyc(input int s, input int p, input int b);
    start = s[0]; pause = p[0]; bonus_hit = b[0];
    step();
    start = 1'b0; pause = 1'b0; bonus_hit = 1'b0;
  endtask

  task automatic add(input int s, input int p, input int b, input int tr, input int inc,
                     input int dec, input int st, input int c);
    vec_t v;
    v.s = s[0]; v.p = p[0]; v.b = b[0];
    v.exp = mk(tr, inc, dec, 0, st, c);
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int i0, d0, k, zero_at, last, gap;
    // start, 4-cycle ticks, bonus just before a tick, pause/resume, restart while running
    add(1,0,0, 1,0,0,1,0);
    add(0,0,0, 0,0,0,1,20);
    add(0,0,0, 0,0,0,1,20);
    add(0,0,0, 0,0,0,1,20);
    add(0,0,0, 0,0,1,1,20);
    add(0,0,0, 0,0,0,1,19);
    add(0,0,0, 0,0,0,1,19);
    add(0,0,1, 0,0,0,1,19);
    add(0,0,0, 0,0,1,1,19);
    add(0,0,0, 0,0,0,1,18);
    add(0,0,0, 0,1,0,1,18);
    add(0,0,0, 0,0,0,1,19);
    add(0,0,0, 0,0,1,1,19);
    add(0,0,0, 0,0,0,1,18);
    add(0,0,0, 0,1,0,1,18);
    add(0,0,0, 0,0,0,1,19);
    add(0,0,0, 0,0,1,1,19);
    add(0,1,0, 0,0,0,2,18);
    add(0,0,1, 0,0,0,2,18);
    add(0,0,0, 0,0,0,2,18);
    add(0,1,0, 0,0,0,1,18);
    add(0,0,0, 0,0,0,1,18);
    add(0,0,0, 0,0,0,1,18);
    add(0,0,0, 0,0,0,1,18);
    add(0,0,0, 0,0,1,1,18);
    add(0,0,0, 0,0,0,1,17);
    add(1,0,0, 1,0,0,1,17);
    add(0,0,0, 0,0,0,1,20);

    repeat (2) @(negedge clk);
    chk("reset_state", int'(snap()), int'(mk(0,0,0,0,0,0)));
    reset = 1'b0;
    step();
    chk("idle_after_reset", int'(snap()), int'(mk(0,0,0,0,0,0)));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].s; pause = tbl[i].p; bonus_hit = tbl[i].b;
      sb.push_back(tbl[i].exp);
      step();
      start = 1'b0; pause = 1'b0; bonus_hit = 1'b0;
      chk($sformatf("vec%0d", i), int'(snap()), int'(sb.pop_front()));
    end

    // pause with prescaler at 2, bonus during pause, resume
    cyc(1,0,0); cyc(0,0,0); cyc(0,0,0);
    cyc(0,1,0);
    chk("pause_state", int'(state), 2);
    i0 = n_inc; d0 = n_dec;
    for (int j = 0; j < 10; j++) cyc(0, 0, int'(j == 3));
    chk("pause_no_inc", n_inc - i0, 0);
    chk("pause_no_dec", n_dec - d0, 0);
    cyc(0,1,0);
    chk("resume_state", int'({state, decrement}), 2);
    cyc(0,0,0);
    chk("resume_dec_early", int'(decrement), 0);
    cyc(0,0,0);
    chk("resume_dec", int'(decrement), 1);
    chk("pause_bonus_ignored", n_inc - i0, 0);
    cyc(0,1,0);
    cyc(1,0,0);
    chk("start_from_pause", int'({timer_reset, state}), 5);

    // uninterrupted run to expiry
    d0 = n_dec; zero_at = -1;
    for (k = 0; k < 200 && !game_over; k++) begin
      step();
      if (cnt_m == 8'd0 && zero_at < 0) zero_at = k;
    end
    chk("expire_seen", int'(game_over), 1);
    chk("expire_latency", int'(zero_at >= 0 && (k - 1 - zero_at) <= 2), 1);
    chk("expire_state", int'(state), 3);
    chk("expire_dec_total", n_dec - d0, 20);
    i0 = n_inc; d0 = n_dec;
    for (int j = 0; j < 50; j++) cyc(0, int'(j % 7 == 0), int'(j % 5 == 0));
    chk("expired_no_pulses", (n_inc - i0) + (n_dec - d0), 0);
    chk("expired_hold", int'({game_over, state, count}), int'({1'b1, 2'd3, 8'd0}));
    cyc(1,0,0);
    chk("restart_expired", int'({timer_reset, game_over, state}), 9);
    cyc(0,0,0); cyc(0,0,0);
    chk("restart_running", int'({state, count}), int'({2'd1, 8'd20}));

    // bonus at count 15
    for (k = 0; k < 100 && cnt_m != 8'd15; k++) step();
    chk("reach15", int'(cnt_m), 15);
    i0 = n_inc; d0 = n_dec; last = -100; gap = 100;
    for (int t = 1; t <= 13; t++) begin
      cyc(0, 0, int'(t == 1));
      if (increment) begin
        if (t - last < gap) gap = t - last;
        last = t;
      end
    end
    chk("bonus_incs", n_inc - i0, 2);
    chk("bonus_gap", int'(gap >= 2), 1);
    chk("bonus_count", int'(cnt_m), 17 - (n_dec - d0));
    i0 = n_inc;
    repeat (20) cyc(0,0,0);
    chk("pending_drained", n_inc - i0, 0);

    // count at 255 with bonuses queued
    for (k = 0; k < 20 && !decrement; k++) step();
    chk("dec_seen", int'(decrement), 1);
    i0 = n_inc;
    load = 1'b1; load_val = 8'd255;
    cyc(0,0,1);
    load = 1'b0;
    cyc(0,0,1); cyc(0,0,1);
    chk("sat_no_inc", n_inc - i0, 0);
    chk("sat_count", int'(cnt_m), 255);
    repeat (4) cyc(0,0,0);
    chk("sat_refill_inc", n_inc - i0, 1);
    chk("sat_refill_count", int'(cnt_m), 255);

    // asynchronous reset while a pulse is on the wire
    for (k = 0; k < 20 && !(increment || decrement); k++) step();
    chk("pulse_seen", int'(increment || decrement), 1);
    #2 reset = 1'b1;
    #1 chk("async_reset", int'({timer_reset, increment, decrement, game_over, state}), 0);
    step();
    reset = 1'b0;
    i0 = n_inc; d0 = n_dec;
    cyc(0,1,1); cyc(0,0,1);
    chk("idle_quiet", int'({timer_reset, state}) + (n_inc - i0) + (n_dec - d0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
